// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending-write counters for RAW stalls.
// WB_BYPASS_EN: forward wb_data to reads and clear pending during WB.
module reg_file_scoreboard #(
    parameter int WORD_LEN          = 32,
    parameter int REG_FILE_ADDR_LEN = 5,
    parameter int REG_COUNT         = 32,
    parameter int MAX_INFLIGHT      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2,
    input  logic                         is_imm,
    input  logic                         st_or_bne,
    input  logic                         issue_valid,
    input  logic                         issue_wb_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] issue_dest,
    input  logic                         wb_we,
    input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
    input  logic [WORD_LEN-1:0]          wb_data,
    input  logic                         retire_valid,
    output logic [WORD_LEN-1:0]          reg1,
    output logic [WORD_LEN-1:0]          reg2,
    output logic                         hazard_detected,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    localparam int AW = REG_FILE_ADDR_LEN;
    localparam int CW = 2;
    localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

    logic [WORD_LEN-1:0] regs_q [REG_COUNT];
    logic [WORD_LEN-1:0] regs_d [REG_COUNT];
    logic [CW-1:0]       cnt_q  [REG_COUNT];
    logic [CW-1:0]       cnt_d  [REG_COUNT];
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [REG_COUNT-1:0] pend;
    logic                 src2_used;
    logic                 issue_acc;
    logic                 ret;
    logic                 wb_write;

    assign src2_used = !is_imm || st_or_bne;
    assign ret       = retire_valid && (wb_dest != '0);
    assign wb_write  = wb_we && (wb_dest != '0);

    // Register 0 is never tracked, so its pending bit stays clear.
    always_comb begin
        pend = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
`ifdef WB_BYPASS_EN
            pend[r] = cnt_q[r] !=
                {{(CW-1){1'b0}}, ret && (wb_dest == AW'(r))};
`else
            pend[r] = cnt_q[r] != '0;
`endif
        end
    end

    assign hazard_detected = pend[src1] || (src2_used && pend[src2]);
    assign issue_acc = issue_valid && issue_wb_en &&
                       (issue_dest != '0) && !hazard_detected;

    always_comb begin
        reg1 = (src1 == '0) ? '0 : regs_q[src1];
        reg2 = (src2 == '0) ? '0 : regs_q[src2];
`ifdef WB_BYPASS_EN
        if (wb_write && (wb_dest == src1)) reg1 = wb_data;
        if (wb_write && (wb_dest == src2)) reg2 = wb_data;
`endif
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_write) regs_d[wb_dest] = wb_data;
    end

    // Issue and retire on the same register cancel out.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        for (int r = 1; r < REG_COUNT; r++) begin
            unique case ({issue_acc && (issue_dest == AW'(r)),
                          ret && (wb_dest == AW'(r))})
                2'b10: begin
                    if (cnt_q[r] == CMAX) ovf_d = 1'b1;
                    else cnt_d[r] = cnt_q[r] + CW'(1);
                end
                2'b01: begin
                    if (cnt_q[r] == '0) unf_d = 1'b1;
                    else cnt_d[r] = cnt_q[r] - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard against an array/integer model.
// Honors WB_BYPASS_EN the same way as the design build.
module tb_reg_file_scoreboard;

    localparam int W = 32;
    localparam int A = 5;
    localparam int N = 32;
    localparam int MAXI = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [A-1:0] src1, src2, issue_dest, wb_dest;
    logic         is_imm, st_or_bne, issue_valid, issue_wb_en;
    logic         wb_we, retire_valid;
    logic [W-1:0] wb_data;
    logic [W-1:0] reg1, reg2;
    logic         hazard_detected, overflow_err, underflow_err;

    reg_file_scoreboard dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2),
        .is_imm(is_imm), .st_or_bne(st_or_bne),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_dest(issue_dest),
        .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
        .retire_valid(retire_valid),
        .reg1(reg1), .reg2(reg2),
        .hazard_detected(hazard_detected),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic         hz;
        logic         ov;
        logic         un;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    logic [W-1:0] mregs [N];
    int           mcnt  [N];
    bit           mov, mun;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            mregs[i] = '0;
            mcnt[i]  = 0;
        end
        mov = 1'b0;
        mun = 1'b0;
    endfunction

    function automatic bit mpend(int r);
        int d;
        if (r == 0) return 1'b0;
        d = (BYP && retire_valid && int'(wb_dest) == r) ? 1 : 0;
        return (mcnt[r] - d) != 0;
    endfunction

    function automatic logic [W-1:0] mread(int a);
        if (BYP && wb_we && wb_dest != 0 && int'(wb_dest) == a)
            return wb_data;
        if (a == 0) return '0;
        return mregs[a];
    endfunction

    function automatic void model_update(bit hz);
        bit acc, rt;
        int i, j;
        acc = issue_valid && issue_wb_en && issue_dest != 0 && !hz;
        rt  = retire_valid && wb_dest != 0;
        i = int'(issue_dest);
        j = int'(wb_dest);
        if (!(acc && rt && i == j)) begin
            if (acc) begin
                if (mcnt[i] == MAXI) mov = 1'b1;
                else mcnt[i]++;
            end
            if (rt) begin
                if (mcnt[j] == 0) mun = 1'b1;
                else mcnt[j]--;
            end
        end
        if (wb_we && wb_dest != 0) mregs[j] = wb_data;
    endfunction

    task automatic idle();
        rst = 1'b1;
        src1 = '0; src2 = '0;
        is_imm = 1'b0; st_or_bne = 1'b0;
        issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = '0;
        wb_we = 1'b0; wb_dest = '0; wb_data = '0;
        retire_valid = 1'b0;
    endtask

    task automatic step(string name);
        exp_t e;
        bit   hz;
        if (!rst) model_clear();
        hz = mpend(int'(src1)) ||
             ((!is_imm || st_or_bne) && mpend(int'(src2)));
        e.name = name;
        e.r1 = mread(int'(src1));
        e.r2 = mread(int'(src2));
        e.hz = hz;
        e.ov = mov;
        e.un = mun;
        q.push_back(e);
        @(posedge clk);
        if (rst) model_update(hz);
        #1;
    endtask

    task automatic issue(logic [A-1:0] d);
        idle();
        issue_valid = 1'b1;
        issue_wb_en = 1'b1;
        issue_dest = d;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if ({reg1, reg2, hazard_detected, overflow_err, underflow_err}
                !== {e.r1, e.r2, e.hz, e.ov, e.un}) begin
                fails++;
                $display("FAIL %s: got r1=%h r2=%h hz=%b ov=%b un=%b want r1=%h r2=%h hz=%b ov=%b un=%b",
                         e.name, reg1, reg2, hazard_detected,
                         overflow_err, underflow_err,
                         e.r1, e.r2, e.hz, e.ov, e.un);
            end
        end
    end

    initial begin
        model_clear();
        idle();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        src1 = 5; src2 = 7;
        rst = 1'b0;
        step("reset_read");

        idle(); wb_we = 1; wb_dest = 3; wb_data = 32'hDEADBEEF;
        step("wr3");
        idle(); src1 = 3;
        step("rd3");
        idle(); wb_we = 1; wb_dest = 0; wb_data = 32'h12345678;
        step("wr0");
        idle(); src1 = 0; src2 = 3;
        step("rd0");

        issue(4);
        step("iss4");
        idle(); src1 = 4;
        step("raw_stall");
        idle(); src1 = 4; retire_valid = 1;
        wb_we = 1; wb_dest = 4; wb_data = 32'hCAFEF00D;
        step("raw_wb");
        idle(); src1 = 4;
        step("raw_after");

        issue(6);
        step("iss6");
        idle(); src2 = 6; is_imm = 1;
        step("src2_imm");
        st_or_bne = 1;
        step("src2_st");
        idle(); src2 = 6;
        step("src2_reg");
        idle(); retire_valid = 1; wb_dest = 6;
        step("ret6");

        issue(8);
        step("iss8");
        issue(8); retire_valid = 1; wb_dest = 8;
        step("iss_ret8");
        idle(); src1 = 8;
        step("cnt8_held");
        issue(9); src1 = 8;
        step("iss9_stall");
        idle(); src1 = 9;
        step("cnt9_zero");
        idle(); retire_valid = 1; wb_dest = 8;
        step("ret8");
        idle(); src1 = 8;
        step("cnt8_clear");

        for (int k = 0; k < 4; k++) begin
            issue(2);
            step("sat_iss2");
        end
        idle(); src1 = 2;
        step("ovf_flag");
        for (int k = 0; k < 3; k++) begin
            idle(); src2 = 2; retire_valid = 1; wb_dest = 2;
            step("drain2");
        end
        idle(); src2 = 2;
        step("drained2");
        idle(); retire_valid = 1; wb_dest = 10;
        step("ret10_zero");
        idle();
        step("unf_flag");
        idle(); src1 = 3;
        step("flags_sticky");
        idle(); src1 = 3; rst = 1'b0;
        step("reset2");
        idle(); src1 = 3;
        step("post_reset");

        for (int k = 0; k < 600; k++) begin
            idle();
            rst = ($urandom_range(0, 99) != 0);
            src1 = A'($urandom_range(0, 15));
            src2 = A'($urandom_range(0, 15));
            is_imm = 1'($urandom);
            st_or_bne = 1'($urandom);
            issue_valid = 1'($urandom);
            issue_wb_en = ($urandom_range(0, 3) != 0);
            issue_dest = A'($urandom_range(0, 15));
            retire_valid = ($urandom_range(0, 2) == 0);
            wb_we = 1'($urandom);
            wb_dest = A'($urandom_range(0, 15));
            wb_data = $urandom;
            step("random");
        end

        idle();
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d checks pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
